// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: drives instruction-memory requests, holds the
// fetched word for decode and handles branch redirects and pipeline flush.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] jump_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush,
    output logic        misalign_err,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc;
    logic [31:0] target;
    logic [2:0]  flush_cnt;
    logic        redirect;

    assign target   = {jump_pc[31:2], 2'b00};
    assign redirect = pc_src && (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = REQ;
            REQ: begin
                if (pc_src)        state_nx = imem_ack ? REQ : DROP;
                else if (imem_ack) state_nx = HOLD;
            end
            HOLD: begin
                if (pc_src || !stall) state_nx = REQ;
            end
            DROP: begin
                if (imem_ack) state_nx = REQ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (state == REQ) || (state == DROP);
        if_valid = (state == HOLD);
    end

    assign imem_addr = fetch_pc;
    assign flush     = (flush_cnt != 3'd0);

    // A late ack for a redirected fetch is dropped; pend_pc holds the newest target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
            if_pc    <= 32'h0;
            if_instr <= 32'h0;
        end else begin
            unique case (state)
                REQ: begin
                    if (pc_src) begin
                        if (imem_ack) fetch_pc <= target;
                        else          pend_pc  <= target;
                    end else if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                HOLD: begin
                    if (pc_src) fetch_pc <= target;
                end
                DROP: begin
                    if (imem_ack) fetch_pc <= pc_src ? target : pend_pc;
                    else if (pc_src) pend_pc <= target;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt    <= 3'd0;
            misalign_err <= 1'b0;
            redirect_cnt <= 16'h0;
        end else begin
            if (redirect)               flush_cnt <= 3'(FLUSH_CYCLES);
            else if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;
            if (redirect && (jump_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
            if (redirect && (redirect_cnt != 16'hFFFF))
                redirect_cnt <= redirect_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch flow, stall, redirects, drop,
// misaligned wrap and reset behaviour.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        pc_src;
    logic [31:0] jump_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        misalign_err;
    logic [15:0] redirect_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_src       (pc_src),
        .jump_pc      (jump_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .flush        (flush),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        pc_src     = 1'b0;
        jump_pc    = 32'h0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        tick();
        tick();
        check("rst_req",      {31'h0, imem_req},     32'h0);
        check("rst_addr",     imem_addr,             32'h0);
        check("rst_valid",    {31'h0, if_valid},     32'h0);
        check("rst_pc",       if_pc,                 32'h0);
        check("rst_instr",    if_instr,              32'h0);
        check("rst_flush",    {31'h0, flush},        32'h0);
        check("rst_misalign", {31'h0, misalign_err}, 32'h0);
        check("rst_rcnt",     {16'h0, redirect_cnt}, 32'h0);

        reset = 1'b0;
        #1;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        tick();
        check("f0_req",  {31'h0, imem_req}, 32'h1);
        check("f0_addr", imem_addr,         32'h0);
        tick();
        check("f0_valid", {31'h0, if_valid}, 32'h1);
        check("f0_pc",    if_pc,             32'h0);
        check("f0_instr", if_instr,          32'h0000_0013);
        check("f0_noreq", {31'h0, imem_req}, 32'h0);
        tick();
        check("f1_addr",  imem_addr,         32'h4);
        check("f1_valid", {31'h0, if_valid}, 32'h0);
        tick();
        check("f1_pc", if_pc, 32'h4);

        stall      = 1'b1;
        imem_rdata = 32'hAAAA_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_valid", {31'h0, if_valid}, 32'h1);
            check("stl_pc",    if_pc,             32'h4);
            check("stl_instr", if_instr,          32'h0000_0013);
            check("stl_noreq", {31'h0, imem_req}, 32'h0);
        end
        stall      = 1'b0;
        imem_rdata = 32'h0000_0013;
        tick();
        check("f2_addr", imem_addr,         32'h8);
        check("f2_req",  {31'h0, imem_req}, 32'h1);
        tick();
        check("f2_pc", if_pc, 32'h8);

        pc_src  = 1'b1;
        jump_pc = 32'h100;
        tick();
        pc_src   = 1'b0;
        imem_ack = 1'b0;
        check("j1_valid", {31'h0, if_valid},     32'h0);
        check("j1_addr",  imem_addr,             32'h100);
        check("j1_flush", {31'h0, flush},        32'h1);
        check("j1_rcnt",  {16'h0, redirect_cnt}, 32'h1);
        tick();
        check("j1_flush2", {31'h0, flush}, 32'h1);
        check("j1_hold",   imem_addr,      32'h100);
        tick();
        check("j1_flush3", {31'h0, flush},     32'h0);
        check("j1_req",    {31'h0, imem_req},  32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_1111;
        tick();
        check("j1_pc",    if_pc,    32'h100);
        check("j1_instr", if_instr, 32'h0000_1111);
        tick();
        check("f3_addr", imem_addr, 32'h104);

        imem_ack = 1'b0;
        pc_src   = 1'b1;
        jump_pc  = 32'h200;
        tick();
        pc_src = 1'b0;
        check("dr_req",   {31'h0, imem_req},     32'h1);
        check("dr_addr",  imem_addr,             32'h104);
        check("dr_flush", {31'h0, flush},        32'h1);
        check("dr_rcnt",  {16'h0, redirect_cnt}, 32'h2);
        tick();
        check("dr_addr2", imem_addr, 32'h104);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        check("dr_valid", {31'h0, if_valid}, 32'h0);
        check("dr_next",  imem_addr,         32'h200);
        check("dr_pc",    if_pc,             32'h100);

        imem_ack = 1'b0;
        pc_src   = 1'b1;
        jump_pc  = 32'h300;
        tick();
        jump_pc = 32'h400;
        tick();
        pc_src = 1'b0;
        check("dd_addr",  imem_addr,             32'h200);
        check("dd_flush", {31'h0, flush},        32'h1);
        check("dd_rcnt",  {16'h0, redirect_cnt}, 32'h4);
        tick();
        check("dd_flush2", {31'h0, flush}, 32'h1);
        imem_ack = 1'b1;
        tick();
        check("dd_next",   imem_addr,         32'h400);
        check("dd_flush3", {31'h0, flush},    32'h0);
        check("dd_valid",  {31'h0, if_valid}, 32'h0);

        pc_src  = 1'b1;
        jump_pc = 32'hFFFF_FFFE;
        tick();
        pc_src = 1'b0;
        check("mw_addr",  imem_addr,             32'hFFFF_FFFC);
        check("mw_err",   {31'h0, misalign_err}, 32'h1);
        check("mw_valid", {31'h0, if_valid},     32'h0);
        check("mw_rcnt",  {16'h0, redirect_cnt}, 32'h5);
        imem_rdata = 32'h5555_5555;
        tick();
        check("mw_pc",    if_pc,    32'hFFFF_FFFC);
        check("mw_instr", if_instr, 32'h5555_5555);
        tick();
        check("mw_wrap", imem_addr,             32'h0);
        check("mw_err2", {31'h0, misalign_err}, 32'h1);

        reset = 1'b1;
        #1;
        check("mr_req",   {31'h0, imem_req},     32'h0);
        check("mr_addr",  imem_addr,             32'h0);
        check("mr_err",   {31'h0, misalign_err}, 32'h0);
        check("mr_rcnt",  {16'h0, redirect_cnt}, 32'h0);
        check("mr_pc",    if_pc,                 32'h0);
        check("mr_instr", if_instr,              32'h0);
        tick();
        pc_src  = 1'b1;
        jump_pc = 32'h800;
        reset   = 1'b0;
        tick();
        pc_src = 1'b0;
        check("ig_addr",  imem_addr,             32'h0);
        check("ig_rcnt",  {16'h0, redirect_cnt}, 32'h0);
        check("ig_flush", {31'h0, flush},        32'h0);
        check("ig_req",   {31'h0, imem_req},     32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
